// File: rtl/comparator_serial_acc_if.sv
// Handshake and per-bit result bundle between a bit-serial driver and comparator_serial_acc.
interface comparator_serial_acc_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             start;
    logic             bit_valid;
    logic             greater;
    logic             less;
    logic             equal;
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             err;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output start, bit_valid, greater, less, equal,
        input  busy, done, gt, lt, eq, err, bit_cnt
    );

    modport slave (
        input  start, bit_valid, greater, less, equal,
        output busy, done, gt, lt, eq, err, bit_cnt
    );
endinterface

// File: rtl/comparator_serial_acc.sv
// Accumulates MSB-first per-bit greater/less/equal results into a WIDTH-bit magnitude compare.
// Optional macro COMPARATOR_SERIAL_EARLY_EXIT_EN: finish the word on the first decisive bit.
module comparator_serial_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic                     clk,
    input logic                     rst_n,
    comparator_serial_acc_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             gt_q;
    logic             lt_q;
    logic             eq_q;
    logic             err_q;
    logic             decided;

    logic             take;
    logic             onehot;
    logic             bit_gt;
    logic             bit_lt;
    logic             decided_nxt;
    logic             last;

    // Illegal (non-one-hot) bits count as equal, so they never decide the word.
    always_comb begin
        onehot      = ({bus.greater, bus.less, bus.equal} == 3'b100) ||
                      ({bus.greater, bus.less, bus.equal} == 3'b010) ||
                      ({bus.greater, bus.less, bus.equal} == 3'b001);
        take        = (state == RUN) && bus.bit_valid;
        bit_gt      = take && onehot && bus.greater && !decided;
        bit_lt      = take && onehot && bus.less && !decided;
        decided_nxt = decided | bit_gt | bit_lt;
        last        = take && (cnt == CNT_LAST);
        state_nxt   = state;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
            RUN:  if (last || bit_gt || bit_lt) state_nxt = DONE;
`else
            RUN:  if (last) state_nxt = DONE;
`endif
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Results persist through IDLE; only a start accepted in IDLE clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
            decided <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            cnt     <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
            decided <= 1'b0;
        end else if (take) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (!onehot)        err_q <= 1'b1;
            if (bit_gt)         gt_q <= 1'b1;
            if (bit_lt)         lt_q <= 1'b1;
            decided <= decided_nxt;
            if (state_nxt == DONE) eq_q <= !decided_nxt;
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.gt      = gt_q;
    assign bus.lt      = lt_q;
    assign bus.eq      = eq_q;
    assign bus.err     = err_q;
    assign bus.bit_cnt = cnt;
endmodule

// File: tb/tb_comparator_serial_acc.sv
// Scoreboard bench for comparator_serial_acc at WIDTH=4; honours COMPARATOR_SERIAL_EARLY_EXIT_EN.
module tb_comparator_serial_acc;
    localparam int W = 4;
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [2:0] BE = 3'b001;
    localparam logic [2:0] BG = 3'b100;
    localparam logic [2:0] BL = 3'b010;
    localparam logic [2:0] BX = 3'b110;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    // Expected word result packed as {gt, lt, eq, err, bit_cnt}.
    logic [6:0] sb[$];

    comparator_serial_acc_if #(.WIDTH(W)) bus ();

    comparator_serial_acc #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [11:0] pat, input int gap, input bit same_bit,
                                 input int start_at, output logic busy_seen,
                                 output logic err_seen, output logic [2:0] gap_cnt);
        logic [2:0] b;
        logic       dec;
        logic       g, l, er;
        logic [2:0] c;
        dec = 0; g = 0; l = 0; er = 0; c = '0;
        for (int i = 0; i < W; i++) begin
            b = pat[11-3*i -: 3];
            c = c + 3'd1;
            if (!(b == BG || b == BL || b == BE)) er = 1'b1;
            else if (!dec && b == BG) begin g = 1'b1; dec = 1'b1; end
            else if (!dec && b == BL) begin l = 1'b1; dec = 1'b1; end
            if (EARLY && dec) break;
        end
        sb.push_back({g, l, !dec, er, c});
        gap_cnt = '0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        if (same_bit) {bus.bit_valid, bus.greater, bus.less, bus.equal} = 4'b1100;
        @(posedge clk); #1;
        bus.start = 1'b0;
        {bus.bit_valid, bus.greater, bus.less, bus.equal} = 4'b0000;
        busy_seen = bus.busy;
        err_seen  = bus.err;
        for (int i = 0; i < W; i++) begin
            b = pat[11-3*i -: 3];
            bus.bit_valid = 1'b1;
            {bus.greater, bus.less, bus.equal} = b;
            bus.start = (i == start_at);
            @(posedge clk); #1;
            {bus.start, bus.bit_valid, bus.greater, bus.less, bus.equal} = 5'b00000;
            if (EARLY && (b == BG || b == BL)) break;
            if (i < W - 1) begin
                for (int k = 0; k < gap; k++) begin
                    @(posedge clk); #1;
                end
                if (i == 1) gap_cnt = bus.bit_cnt;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        {bus.start, bus.bit_valid, bus.greater, bus.less, bus.equal} = 5'b00000;
        #12;
        total++;
        if ({bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt} !== 9'd0) begin
            bad++;
            $display("[TB] FAIL reset_held: outputs=%b want 0", {bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt} !== 9'd0) begin
            bad++;
            $display("[TB] FAIL reset_idle: outputs=%b want 0", {bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt});
        end
    endtask

    task automatic test_gt_basic;
        logic busy_s, err_s;
        logic [2:0] gc;
        logic [6:0] e;
        int lat;
        applyStimulus({BE, BE, BG, BL}, 0, 1'b0, -1, busy_s, err_s, gc);
        total++;
        if (busy_s !== 1'b1) begin bad++; $display("[TB] FAIL gt_busy: got %b want 1", busy_s); end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        e = sb.pop_front();
        total++;
        if (lat != 0) begin bad++; $display("[TB] FAIL gt_latency: waited %0d want 0", lat); end
        total++;
        if ({bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt} !== e) begin
            bad++; $display("[TB] FAIL gt_result: got %b want %b", {bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt}, e);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt} !== {2'b00, e}) begin
            bad++; $display("[TB] FAIL gt_hold: got %b want %b", {bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt}, {2'b00, e});
        end
    endtask

    task automatic test_eq_gaps;
        logic busy_s, err_s;
        logic [2:0] gc;
        logic [6:0] e;
        int lat;
        applyStimulus({BE, BE, BE, BE}, 2, 1'b1, -1, busy_s, err_s, gc);
        total++;
        if (gc !== 3'd2) begin bad++; $display("[TB] FAIL eq_gap_count: got %0d want 2", gc); end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        e = sb.pop_front();
        total++;
        if (lat != 0) begin bad++; $display("[TB] FAIL eq_latency: waited %0d want 0", lat); end
        total++;
        if ({bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt} !== e) begin
            bad++; $display("[TB] FAIL eq_result: got %b want %b", {bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt}, e);
        end
    endtask

    task automatic test_first_decisive;
        logic busy_s, err_s;
        logic [2:0] gc;
        logic [6:0] e;
        int lat;
        applyStimulus({BL, BG, BG, BG}, 0, 1'b0, -1, busy_s, err_s, gc);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        e = sb.pop_front();
        total++;
        if (lat != 0) begin bad++; $display("[TB] FAIL lt_latency: waited %0d want 0", lat); end
        total++;
        if ({bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt} !== e) begin
            bad++; $display("[TB] FAIL lt_result: got %b want %b", {bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt}, e);
        end
    endtask

    task automatic test_illegal;
        logic busy_s, err_s;
        logic [2:0] gc;
        logic [6:0] e;
        int lat;
        applyStimulus({BX, BE, BE, BE}, 0, 1'b0, -1, busy_s, err_s, gc);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        e = sb.pop_front();
        total++;
        if ({bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt} !== e) begin
            bad++; $display("[TB] FAIL illegal_result: got %b want %b (lat %0d)", {bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt}, e, lat);
        end
        applyStimulus({BE, BE, BE, BL}, 0, 1'b0, -1, busy_s, err_s, gc);
        total++;
        if (err_s !== 1'b0) begin bad++; $display("[TB] FAIL illegal_err_clear: got %b want 0", err_s); end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        e = sb.pop_front();
        total++;
        if ({bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt} !== e) begin
            bad++; $display("[TB] FAIL illegal_next_result: got %b want %b (lat %0d)", {bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt}, e, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic busy_s, err_s;
        logic [2:0] gc;
        logic [6:0] e;
        int lat;
        applyStimulus({BE, BG, BE, BE}, 0, 1'b0, 1, busy_s, err_s, gc);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        e = sb.pop_front();
        total++;
        if (lat != 0) begin bad++; $display("[TB] FAIL b2b_latency: waited %0d want 0", lat); end
        total++;
        if ({bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt} !== e) begin
            bad++; $display("[TB] FAIL b2b_result: got %b want %b", {bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt}, e);
        end
    endtask

    task automatic test_reset_mid;
        logic busy_s, err_s;
        logic [2:0] gc;
        logic [6:0] e;
        logic done_seen;
        int lat;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.bit_valid = 1'b1;
        {bus.greater, bus.less, bus.equal} = BX;
        @(posedge clk); #1;
        {bus.greater, bus.less, bus.equal} = BE;
        @(posedge clk); #1;
        {bus.bit_valid, bus.greater, bus.less, bus.equal} = 4'b0000;
        total++;
        if ({bus.busy, bus.err, bus.bit_cnt} !== 5'b11010) begin
            bad++; $display("[TB] FAIL midrun_state: got %b want 11010", {bus.busy, bus.err, bus.bit_cnt});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt} !== 9'd0) begin
            bad++; $display("[TB] FAIL midrun_async_clear: outputs=%b want 0", {bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
        end
        total++;
        if (done_seen !== 1'b0) begin bad++; $display("[TB] FAIL midrun_no_done: activity=%b want 0", done_seen); end
        applyStimulus({BG, BE, BE, BE}, 0, 1'b0, -1, busy_s, err_s, gc);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        e = sb.pop_front();
        total++;
        if ({bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt} !== e) begin
            bad++; $display("[TB] FAIL midrun_restart: got %b want %b (lat %0d)", {bus.gt, bus.lt, bus.eq, bus.err, bus.bit_cnt}, e, lat);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_gt_basic;
        test_eq_gaps;
        test_first_decisive;
        test_illegal;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/comparator_serial_acc.md
Name: comparator_serial_acc

Overview:
- Downstream consumer of the 1-bit comparator's greater/less/equal outputs.
- Accepts one per-bit comparison per valid cycle, MSB first, over WIDTH bits.
- Accumulates the per-bit results into a registered WIDTH-bit magnitude compare (gt/lt/eq) with a start/busy/done handshake.
- Lets the team compare multi-bit words bit-serially through a single 1-bit comparator.

Parameters:
- WIDTH, 8, number of bit comparisons per word (>=2).
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new word compare; sampled high for one cycle.
- bit_valid  input  1  greater/less/equal carry a valid bit result this cycle.
- greater  input  1  per-bit a>b from the 1-bit comparator.
- less  input  1  per-bit a<b from the 1-bit comparator.
- equal  input  1  per-bit a==b from the 1-bit comparator.
- busy  output  1  compare in progress (RUN state).
- done  output  1  one-cycle pulse: result valid.
- gt  output  1  word A > word B.
- lt  output  1  word A < word B.
- eq  output  1  word A == word B.
- err  output  1  sticky: a non-one-hot per-bit input was seen this word.
- bit_cnt  output  CNT_W  number of bits consumed in the current word.

Behaviour:
- Clock/reset: single clock clk. rst_n is asynchronous, active-low; all flops clear immediately on assertion.
- Reset values: state=IDLE, busy=0, done=0, gt=0, lt=0, eq=0, err=0, bit_cnt=0. decided flag=0.
- FSM states:
  - IDLE: start=1 -> RUN; clear gt/lt/eq/err/bit_cnt/decided.
  - RUN: busy=1. Each cycle with bit_valid=1: bit_cnt+1. When bit_cnt reaches WIDTH -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
- Same-cycle start and bit_valid: on the start cycle, bit_valid is ignored; the first bit is taken on the cycle after start.
- start during RUN or DONE: ignored.
- Accumulation, MSB first, while decided=0:
  - greater=1 -> gt=1, decided=1.
  - less=1 -> lt=1, decided=1.
  - equal=1 -> no change.
- Once decided=1, later bits are counted but do not alter gt/lt.
- On the transition RUN->DONE: eq is set to !decided, so exactly one of gt/lt/eq is 1 when done=1.
- Results gt/lt/eq/err hold through IDLE until the next start.
- Illegal input: when bit_valid=1 and {greater,less,equal} is not one-hot, set err=1 (sticky until the next start) and treat the bit as equal.
- bit_valid=0 during RUN: state, count and results hold (stall). There is no timeout.
- Latency: done rises on the clock edge after the WIDTH-th valid bit is sampled. Minimum start-to-done is WIDTH+1 cycles.
- Reset mid-RUN: abort to IDLE immediately; all outputs return to reset values. No done pulse is issued.
- bit_cnt saturates at WIDTH; it never wraps.

Optional Feature:
- Macro: COMPARATOR_SERIAL_EARLY_EXIT_EN.
- Defined: in RUN, the first decisive bit (greater or less) moves the FSM straight to DONE on that edge. done pulses the next cycle and bit_cnt freezes at the bits consumed. Remaining bits need not be driven; bit_valid is ignored outside RUN.
- Undefined: always consume exactly WIDTH bits as described above.
- eq is only ever set after WIDTH equal bits, in both builds.

Test Plan (WIDTH=4):
1. Reset release, idle -> all outputs 0; start pulse -> busy=1 the next cycle.
2. Bits e,e,g,l (A=0010, B=0001 pattern) on consecutive cycles -> done one cycle after 4th bit; gt=1, lt=0, eq=0, bit_cnt=4, err=0.
3. Bits e,e,e,e with bit_valid gaps of 2 idle cycles between each -> count holds during gaps; done after 4th valid bit; eq=1, gt=lt=0.
4. Bits l,g,g,g -> lt=1 (first decisive bit wins), gt=0. With COMPARATOR_SERIAL_EARLY_EXIT_EN: done one cycle after the 1st bit, bit_cnt=1.
5. Bit with greater=1 and less=1, then e,e,e -> err=1, eq=1 at done. The next start clears err to 0.
6. rst_n pulled low after 2 bits -> outputs 0 immediately with no clock edge, no done pulse. A new start then 4 bits g,e,e,e -> gt=1.
